lsu_lq_tracked: RTL and testbench

Parametrised load queue for the LSU that tracks each load from issue through execution to retirement and flags loads mis-speculated by a retiring store. Compared with the single-address load queue it adds per-entry load size, an explicit executed state, byte-range overlap detection, an occupancy count, and a same-cycle store/retire bypass. It sits between LSU_ID (allocate), the LSU execute/response path (execute mark), the SQ (retiring stores) and the ROB (load retirement).

---
 rtl/lsu_lq_tracked.sv | 149 ++++++++++++++
 tb/tb_lsu_lq_tracked.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_lq_tracked.sv
// Load queue that tracks loads from allocation through execution to retirement and
// flags executed loads whose bytes are overwritten by a retiring store.
module lsu_lq_tracked #(
    parameter int LQ_DEPTH   = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 6,
    parameter int FUNC_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        i_flush,
    output logic                        o_full,
    output logic [$clog2(LQ_DEPTH):0]   o_count,
    input  logic                        i_alloc_en,
    input  logic [TAG_WIDTH-1:0]        i_alloc_tag,
    input  logic [ADDR_WIDTH-1:0]       i_alloc_addr,
    input  logic [FUNC_WIDTH-1:0]       i_alloc_lsu_func,
    output logic [$clog2(LQ_DEPTH)-1:0] o_alloc_slot,
    input  logic                        i_exec_en,
    input  logic [$clog2(LQ_DEPTH)-1:0] i_exec_slot,
    input  logic                        i_sq_retire_en,
    input  logic [ADDR_WIDTH-1:0]       i_sq_retire_addr,
    input  logic [FUNC_WIDTH-1:0]       i_sq_retire_lsu_func,
    input  logic                        i_rob_retire_en,
    input  logic [TAG_WIDTH-1:0]        i_rob_retire_tag,
    output logic                        o_rob_retire_hit,
    output logic                        o_rob_retire_mis_speculated
);
    localparam int IDX_W = $clog2(LQ_DEPTH);

    localparam logic [FUNC_WIDTH-1:0] LSU_FUNC_LB  = FUNC_WIDTH'(0);
    localparam logic [FUNC_WIDTH-1:0] LSU_FUNC_LBU = FUNC_WIDTH'(1);
    localparam logic [FUNC_WIDTH-1:0] LSU_FUNC_LH  = FUNC_WIDTH'(2);
    localparam logic [FUNC_WIDTH-1:0] LSU_FUNC_LHU = FUNC_WIDTH'(3);
    localparam logic [FUNC_WIDTH-1:0] LSU_FUNC_SB  = FUNC_WIDTH'(5);
    localparam logic [FUNC_WIDTH-1:0] LSU_FUNC_SH  = FUNC_WIDTH'(6);

    typedef enum logic [1:0] {
        LQ_INVALID   = 2'd0,
        LQ_ALLOCATED = 2'd1,
        LQ_EXECUTED  = 2'd2
    } lq_state_t;

    function automatic logic [2:0] size_decode(input logic [FUNC_WIDTH-1:0] func);
        case (func)
            LSU_FUNC_LB, LSU_FUNC_LBU, LSU_FUNC_SB: size_decode = 3'd1;
            LSU_FUNC_LH, LSU_FUNC_LHU, LSU_FUNC_SH: size_decode = 3'd2;
            default:                                size_decode = 3'd4;
        endcase
    endfunction

    // End addresses carry one extra bit so ranges touching the top of memory never wrap.
    function automatic logic overlaps(input logic [ADDR_WIDTH-1:0] la, input logic [2:0] lsize,
                                      input logic [ADDR_WIDTH-1:0] sa, input logic [2:0] ssize);
        logic [ADDR_WIDTH:0] lend;
        logic [ADDR_WIDTH:0] send;
        lend = {1'b0, la} + {{(ADDR_WIDTH-2){1'b0}}, lsize};
        send = {1'b0, sa} + {{(ADDR_WIDTH-2){1'b0}}, ssize};
        overlaps = ({1'b0, sa} < lend) && ({1'b0, la} < send);
    endfunction

    lq_state_t             state_q    [LQ_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q     [LQ_DEPTH];
    logic [TAG_WIDTH-1:0]  tag_q      [LQ_DEPTH];
    logic [2:0]            size_q     [LQ_DEPTH];
    logic [LQ_DEPTH-1:0]   mis_spec_q;

    logic [LQ_DEPTH-1:0] valid;
    logic [LQ_DEPTH-1:0] exec_now;
    logic [LQ_DEPTH-1:0] store_hit;
    logic [LQ_DEPTH-1:0] retire_select;
    logic [IDX_W-1:0]    alloc_slot;
    logic [IDX_W:0]      count;
    logic                full;
    logic                alloc_accept;
    logic                retire_mis;
    logic [2:0]          store_size;

    assign store_size = size_decode(i_sq_retire_lsu_func);

    always_comb begin
        valid         = '0;
        exec_now      = '0;
        store_hit     = '0;
        retire_select = '0;
        alloc_slot    = '0;
        count         = '0;
        // Descending scan so the lowest free index is the last one written.
        for (int i = LQ_DEPTH - 1; i >= 0; i--) begin
            valid[i]         = (state_q[i] != LQ_INVALID);
            exec_now[i]      = i_exec_en && (i_exec_slot == IDX_W'(i)) && (state_q[i] == LQ_ALLOCATED);
            store_hit[i]     = i_sq_retire_en && ((state_q[i] == LQ_EXECUTED) || exec_now[i]) &&
                               overlaps(addr_q[i], size_q[i], i_sq_retire_addr, store_size);
            retire_select[i] = i_rob_retire_en && valid[i] && (tag_q[i] == i_rob_retire_tag);
            if (!valid[i]) alloc_slot = IDX_W'(i);
            count = count + (IDX_W+1)'(valid[i]);
        end
    end

    always_comb begin
        retire_mis = 1'b0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (retire_select[i]) retire_mis = retire_mis | mis_spec_q[i] | store_hit[i];
        end
    end

    assign full                        = &valid;
    assign alloc_accept                = i_alloc_en && !full && !i_flush;
    assign o_full                      = full;
    assign o_count                     = count;
    assign o_alloc_slot                = alloc_slot;
    assign o_rob_retire_hit            = |retire_select;
    assign o_rob_retire_mis_speculated = retire_mis;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < LQ_DEPTH; i++) begin
                state_q[i]    <= LQ_INVALID;
                mis_spec_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < LQ_DEPTH; i++) begin
                if (i_flush) begin
                    state_q[i]    <= LQ_INVALID;
                    mis_spec_q[i] <= 1'b0;
                end else if (alloc_accept && (alloc_slot == IDX_W'(i))) begin
                    state_q[i]    <= LQ_ALLOCATED;
                    mis_spec_q[i] <= 1'b0;
                end else if (retire_select[i]) begin
                    state_q[i]    <= LQ_INVALID;
                    mis_spec_q[i] <= 1'b0;
                end else begin
                    if (exec_now[i])  state_q[i]    <= LQ_EXECUTED;
                    if (store_hit[i]) mis_spec_q[i] <= 1'b1;
                end
            end
        end
    end

    // Payload is only meaningful while the entry is valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (alloc_accept) begin
            addr_q[alloc_slot] <= i_alloc_addr;
            tag_q[alloc_slot]  <= i_alloc_tag;
            size_q[alloc_slot] <= size_decode(i_alloc_lsu_func);
        end
    end

endmodule

// File: tb/tb_lsu_lq_tracked.sv
// Bench for lsu_lq_tracked: directed scenarios followed by random traffic, all checked
// against a slot-level reference model of the load queue.
module tb_lsu_lq_tracked;
    localparam logic [3:0] LB = 4'd0, LBU = 4'd1, LH = 4'd2, LHU = 4'd3, LW = 4'd4;
    localparam logic [3:0] SB = 4'd5, SH = 4'd6, SW = 4'd7;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        i_flush;
    logic        o_full;
    logic [3:0]  o_count;
    logic        i_alloc_en;
    logic [5:0]  i_alloc_tag;
    logic [31:0] i_alloc_addr;
    logic [3:0]  i_alloc_lsu_func;
    logic [2:0]  o_alloc_slot;
    logic        i_exec_en;
    logic [2:0]  i_exec_slot;
    logic        i_sq_retire_en;
    logic [31:0] i_sq_retire_addr;
    logic [3:0]  i_sq_retire_lsu_func;
    logic        i_rob_retire_en;
    logic [5:0]  i_rob_retire_tag;
    logic        o_rob_retire_hit;
    logic        o_rob_retire_mis_speculated;

    int tests = 0;
    int fails = 0;

    // Reference model: one record per slot.
    bit          mv [8];
    bit          me [8];
    bit          mm [8];
    logic [31:0] ma [8];
    logic [5:0]  mt [8];
    int          ms [8];

    lsu_lq_tracked #(.LQ_DEPTH(8), .ADDR_WIDTH(32), .TAG_WIDTH(6), .FUNC_WIDTH(4)) dut (
        .clk(clk), .n_rst(n_rst), .i_flush(i_flush), .o_full(o_full), .o_count(o_count),
        .i_alloc_en(i_alloc_en), .i_alloc_tag(i_alloc_tag), .i_alloc_addr(i_alloc_addr),
        .i_alloc_lsu_func(i_alloc_lsu_func), .o_alloc_slot(o_alloc_slot),
        .i_exec_en(i_exec_en), .i_exec_slot(i_exec_slot),
        .i_sq_retire_en(i_sq_retire_en), .i_sq_retire_addr(i_sq_retire_addr),
        .i_sq_retire_lsu_func(i_sq_retire_lsu_func),
        .i_rob_retire_en(i_rob_retire_en), .i_rob_retire_tag(i_rob_retire_tag),
        .o_rob_retire_hit(o_rob_retire_hit),
        .o_rob_retire_mis_speculated(o_rob_retire_mis_speculated)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sz(input logic [3:0] f);
        case (f)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            default:     return 4;
        endcase
    endfunction

    function automatic bit ovl(input logic [31:0] la, input int ls, input logic [31:0] sa, input int ss);
        longint l = longint'(la);
        longint s = longint'(sa);
        return (s < l + ls) && (l < s + ss);
    endfunction

    function automatic bit live(input logic [5:0] t);
        for (int i = 0; i < 8; i++) if (mv[i] && mt[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            mv[i] = 1'b0; me[i] = 1'b0; mm[i] = 1'b0;
        end
    endtask

    task automatic idle();
        i_flush = 0; i_alloc_en = 0; i_alloc_tag = '0; i_alloc_addr = '0; i_alloc_lsu_func = '0;
        i_exec_en = 0; i_exec_slot = '0; i_sq_retire_en = 0; i_sq_retire_addr = '0;
        i_sq_retire_lsu_func = '0; i_rob_retire_en = 0; i_rob_retire_tag = '0;
    endtask

    task automatic set_alloc(input logic [5:0] t, input logic [31:0] a, input logic [3:0] f);
        i_alloc_en = 1; i_alloc_tag = t; i_alloc_addr = a; i_alloc_lsu_func = f;
    endtask

    task automatic set_exec(input logic [2:0] s);
        i_exec_en = 1; i_exec_slot = s;
    endtask

    task automatic set_store(input logic [31:0] a, input logic [3:0] f);
        i_sq_retire_en = 1; i_sq_retire_addr = a; i_sq_retire_lsu_func = f;
    endtask

    task automatic set_retire(input logic [5:0] t);
        i_rob_retire_en = 1; i_rob_retire_tag = t;
    endtask

    // Check outputs against the model for the current inputs, clock once, advance the model.
    task automatic step();
        int  cnt, slot, h;
        bit  xn [8];
        bit  ov [8];
        bit  exp_mis;
        #1;
        cnt = 0; slot = -1; h = -1;
        for (int i = 0; i < 8; i++) begin
            if (mv[i]) cnt++;
            else if (slot < 0) slot = i;
            xn[i] = i_exec_en && (int'(i_exec_slot) == i) && mv[i] && !me[i];
            ov[i] = i_sq_retire_en && mv[i] && ovl(ma[i], ms[i], i_sq_retire_addr, sz(i_sq_retire_lsu_func));
            if (i_rob_retire_en && mv[i] && mt[i] == i_rob_retire_tag) h = i;
        end
        exp_mis = (h >= 0) && (mm[h] || (ov[h] && (me[h] || xn[h])));
        chk("count", o_count, cnt);
        chk("full", o_full, cnt == 8);
        if (slot >= 0) chk("alloc_slot", o_alloc_slot, slot);
        chk("retire_hit", o_rob_retire_hit, h >= 0);
        chk("retire_mis", o_rob_retire_mis_speculated, exp_mis);
        @(posedge clk);
        if (i_flush) begin
            model_clear();
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (i_alloc_en && slot >= 0 && i == slot) begin
                    mv[i] = 1; me[i] = 0; mm[i] = 0;
                    ma[i] = i_alloc_addr; mt[i] = i_alloc_tag; ms[i] = sz(i_alloc_lsu_func);
                end else if (i == h) begin
                    mv[i] = 0; me[i] = 0; mm[i] = 0;
                end else begin
                    if (ov[i] && (me[i] || xn[i])) mm[i] = 1;
                    if (xn[i]) me[i] = 1;
                end
            end
        end
        #1;
        idle();
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 + $urandom_range(0, 15);
        return 32'h0000_1000 + $urandom_range(0, 15);
    endfunction

    task automatic rand_inputs();
        logic [5:0] t;
        int         s;
        if ($urandom_range(0, 49) == 0) i_flush = 1;
        if ($urandom_range(0, 1) == 1) begin
            do t = 6'($urandom_range(0, 63)); while (live(t));
            set_alloc(t, rand_addr(), ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 4)));
        end
        if ($urandom_range(0, 1) == 1) set_exec(3'($urandom_range(0, 7)));
        if ($urandom_range(0, 9) < 3) set_store(rand_addr(), 4'(5 + $urandom_range(0, 2)));
        if ($urandom_range(0, 9) < 4) begin
            s = $urandom_range(0, 7);
            if (mv[s] && $urandom_range(0, 4) != 0) set_retire(mt[s]);
            else set_retire(6'($urandom_range(0, 63)));
        end
    endtask

    initial begin
        n_rst = 0;
        idle();
        model_clear();
        #12;
        chk("rst_count", o_count, 0);
        chk("rst_full", o_full, 0);
        chk("rst_slot", o_alloc_slot, 0);
        chk("rst_hit", o_rob_retire_hit, 0);
        chk("rst_mis", o_rob_retire_mis_speculated, 0);
        n_rst = 1;

        // Fill all eight slots in order, then try a ninth.
        for (int i = 0; i < 8; i++) begin
            set_alloc(6'(i + 1), 32'h10 * i, LW);
            #1 chk("fill_slot", o_alloc_slot, i);
            step();
        end
        chk("fill_count", o_count, 8);
        chk("fill_full", o_full, 1);
        set_alloc(6'd9, 32'h200, LW);
        step();
        chk("drop_count", o_count, 8);
        i_flush = 1;
        step();
        chk("flush_count", o_count, 0);

        // Executed LW at 0x100 vs SB at 0x103 (overlap) and at 0x104 (adjacent).
        set_alloc(6'd10, 32'h100, LW); step();
        set_exec(3'd0); step();
        set_store(32'h103, SB); step();
        set_retire(6'd10);
        #1 chk("sb103_hit", o_rob_retire_hit, 1);
        chk("sb103_mis", o_rob_retire_mis_speculated, 1);
        step();
        set_alloc(6'd11, 32'h100, LW); step();
        set_exec(3'd0); step();
        set_store(32'h104, SB); step();
        set_retire(6'd11);
        #1 chk("sb104_mis", o_rob_retire_mis_speculated, 0);
        step();

        // Store hits a load that has not executed yet: no replay needed.
        set_alloc(6'd12, 32'h200, LH); step();
        set_store(32'h200, SW); step();
        set_exec(3'd0); step();
        set_retire(6'd12);
        #1 chk("alloc_only_mis", o_rob_retire_mis_speculated, 0);
        step();

        // Store and load retire in the same cycle.
        set_alloc(6'd13, 32'h302, LB); step();
        set_exec(3'd0); step();
        set_store(32'h300, SW); set_retire(6'd13);
        #1 chk("bypass_mis", o_rob_retire_mis_speculated, 1);
        step();
        chk("bypass_freed", o_count, 0);

        // Retire slot 2 while allocating; the freed slot waits a cycle.
        for (int i = 0; i < 4; i++) begin set_alloc(6'(20 + i), 32'h400 + 32'(i * 8), LW); step(); end
        set_retire(6'd22); set_alloc(6'd24, 32'h500, LW);
        #1 chk("reuse_slot4", o_alloc_slot, 4);
        step();
        chk("reuse_count", o_count, 4);
        set_alloc(6'd25, 32'h600, LW);
        #1 chk("reuse_slot2", o_alloc_slot, 2);
        step();

        // Flush with a concurrent alloc, then retire an old tag.
        i_flush = 1; set_alloc(6'd26, 32'h700, LW); step();
        chk("flush2_count", o_count, 0);
        chk("flush2_full", o_full, 0);
        set_retire(6'd20);
        #1 chk("old_tag_hit", o_rob_retire_hit, 0);
        step();

        // Top-of-memory ranges must not wrap.
        set_alloc(6'd30, 32'hFFFF_FFFC, LW); step();
        set_exec(3'd0); step();
        set_store(32'h0, SW); step();
        set_store(32'hFFFF_FFFF, SB); set_retire(6'd30);
        #1 chk("top_bypass_mis", o_rob_retire_mis_speculated, 1);
        step();
        set_alloc(6'd31, 32'hFFFF_FFFC, LW); step();
        set_exec(3'd0); step();
        set_store(32'h0, SW); step();
        set_retire(6'd31);
        #1 chk("nowrap_mis", o_rob_retire_mis_speculated, 0);
        step();

        // Random traffic with an occasional asynchronous reset between clock edges.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                #2 n_rst = 0;
                #1 chk("async_rst_count", o_count, 0);
                chk("async_rst_full", o_full, 0);
                model_clear();
                #1 n_rst = 1;
            end
            rand_inputs();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
